// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and bit-mixing helpers.
package sha256_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BLOCK_W    = 512;
    localparam int unsigned NUM_ROUNDS = 64;
    localparam int unsigned WIN_N      = BLOCK_W / WORD_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } sched_state_t;

    // Rotate right by a constant amount.
    function automatic logic [WORD_W-1:0] sha_rotr(input logic [WORD_W-1:0] x,
                                                   input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    // Message-schedule small sigma0.
    function automatic logic [WORD_W-1:0] sha_sigma0(input logic [WORD_W-1:0] x);
        return sha_rotr(x, 7) ^ sha_rotr(x, 18) ^ (x >> 3);
    endfunction

    // Message-schedule small sigma1.
    function automatic logic [WORD_W-1:0] sha_sigma1(input logic [WORD_W-1:0] x);
        return sha_rotr(x, 17) ^ sha_rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/msg_sched_expand.sv
// Combinational next-word generator for the 16-word schedule window.
module msg_sched_expand
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] win0,
    input  logic [WORD_W-1:0] win1,
    input  logic [WORD_W-1:0] win9,
    input  logic [WORD_W-1:0] win14,
    output logic [WORD_W-1:0] next_word
);

    // W_t = s1(W_t-2) + W_t-7 + s0(W_t-15) + W_t-16, carries dropped.
    always_comb begin
        next_word = sha_sigma1(win14) + win9 + sha_sigma0(win1) + win0;
    end

endmodule

// File: rtl/msg_schedule.sv
// Streams the SHA-256 message schedule W0..W(ROUNDS-1) for one captured block.
module msg_schedule
    import sha256_pkg::*;
#(
    parameter  int unsigned ROUNDS = NUM_ROUNDS,
    localparam int unsigned IDX_W  = $clog2(ROUNDS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 message_vector_complete,
    input  logic [BLOCK_W-1:0]   message_vector,
    input  logic                 w_ready,
    output logic                 w_valid,
    output logic [IDX_W-1:0]     w_index,
    output logic [WORD_W-1:0]    w_word,
    output logic                 schedule_busy,
    output logic                 schedule_complete
);

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic              r_mvc_q;
    logic [WORD_W-1:0] r_win [WIN_N];
    logic [IDX_W-1:0]  r_index;
    logic              r_valid;
    logic              r_busy;
    logic              r_complete;
    logic [WORD_W-1:0] w_next_word;
    logic              w_start;
    logic              w_accept;
    logic              w_last;

    msg_sched_expand u_expand (
        .win0      (r_win[0]),
        .win1      (r_win[1]),
        .win9      (r_win[9]),
        .win14     (r_win[14]),
        .next_word (w_next_word)
    );

    // Handshake qualifiers shared by the FSM and the datapath.
    always_comb begin
        w_start  = message_vector_complete & ~r_mvc_q;
        w_accept = r_valid & w_ready;
        w_last   = w_accept && (r_index == IDX_W'(ROUNDS - 1));
    end

    // State register; disable behaves like reset.
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: start edge only honoured in IDLE, leave RUN on final accept.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Window capture/slide, index and handshake flags.
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            r_mvc_q    <= 1'b0;
            r_index    <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_complete <= 1'b0;
            for (int i = 0; i < int'(WIN_N); i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_mvc_q    <= message_vector_complete;
            r_complete <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_start) begin
                    for (int i = 0; i < int'(WIN_N); i++) begin
                        r_win[i] <= message_vector[BLOCK_W-1-WORD_W*i -: WORD_W];
                    end
                    r_index <= '0;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b1;
                end
            end else if (w_accept) begin
                for (int i = 0; i < int'(WIN_N) - 1; i++) begin
                    r_win[i] <= r_win[i+1];
                end
                r_win[WIN_N-1] <= w_next_word;
                r_index        <= r_index + IDX_W'(1);
                if (w_last) begin
                    r_valid    <= 1'b0;
                    r_busy     <= 1'b0;
                    r_complete <= 1'b1;
                end
            end
        end
    end

    // Output word is the head of the window while a schedule is running.
    always_comb begin
        w_word = (r_state == S_RUN) ? r_win[0] : '0;
    end

    assign w_valid           = r_valid;
    assign w_index           = r_index;
    assign schedule_busy     = r_busy;
    assign schedule_complete = r_complete;

endmodule

// File: tb/tb_msg_schedule.sv
// Self-checking bench for msg_schedule.
module tb_msg_schedule;

    localparam int unsigned ROUNDS = 64;
    localparam int unsigned IDX_W  = 6;

    typedef logic [15:0][31:0] blk_t;
    typedef logic [63:0][31:0] sch_t;

    typedef struct {
        string       name;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             message_vector_complete;
    logic [511:0]     message_vector;
    logic             w_ready;
    logic             w_valid;
    logic [IDX_W-1:0] w_index;
    logic [31:0]      w_word;
    logic             schedule_busy;
    logic             schedule_complete;

    int n_cmp = 0;
    int n_bad = 0;

    sch_t got;
    sch_t mdl_abc;
    sch_t mdl_ones;
    blk_t blk_abc;
    blk_t blk_ones;

    msg_schedule #(.ROUNDS(ROUNDS)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .enable                  (enable),
        .message_vector_complete (message_vector_complete),
        .message_vector          (message_vector),
        .w_ready                 (w_ready),
        .w_valid                 (w_valid),
        .w_index                 (w_index),
        .w_word                  (w_word),
        .schedule_busy           (schedule_busy),
        .schedule_complete       (schedule_complete)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return 32'(d >> n);
    endfunction

    function automatic sch_t build_model(input blk_t b);
        sch_t w;
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) w[t] = b[t];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = 32'(64'(s1) + 64'(w[t-7]) + 64'(s0) + 64'(w[t-16]));
        end
        return w;
    endfunction

    function automatic logic [511:0] to_vec(input blk_t b);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[511-32*i -: 32] = b[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One-cycle pulse on message_vector_complete; returns with W0 already visible.
    task automatic start_block(input blk_t b);
        message_vector          = to_vec(b);
        message_vector_complete = 1'b1;
        step();
        message_vector_complete = 1'b0;
    endtask

    // Drain one schedule into 'got', checking order, stalls and the completion pulse.
    task automatic collect(input bit rnd, input int poke_at, output int n_acc, output int cycles);
        logic [31:0]      pw;
        logic [IDX_W-1:0] pi;
        bit pstall, poked, mvc_hi;
        int stall_err, early_err, order_err;
        n_acc = 0; cycles = 0; pstall = 0; poked = 0; mvc_hi = 0;
        stall_err = 0; early_err = 0; order_err = 0;
        pw = '0; pi = '0;
        got = '1;
        while (n_acc < int'(ROUNDS) && cycles < 2000) begin
            w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mvc_hi) begin
                message_vector_complete = 1'b0;
                mvc_hi = 0;
            end
            if (poke_at >= 0 && !poked && n_acc == poke_at) begin
                message_vector_complete = 1'b1;
                message_vector          = ~message_vector;
                poked  = 1;
                mvc_hi = 1;
            end
            @(negedge clock);
            if (schedule_complete !== 1'b0 || w_valid !== 1'b1 || schedule_busy !== 1'b1)
                early_err++;
            if (pstall && (w_word !== pw || w_index !== pi)) stall_err++;
            if (w_ready) begin
                got[w_index] = w_word;
                if (int'(w_index) != n_acc) order_err++;
                n_acc++;
            end
            pstall = !w_ready;
            pw = w_word;
            pi = w_index;
            step();
            cycles++;
        end
        w_ready = 1'b0;
        message_vector_complete = 1'b0;
        @(negedge clock);
        chk("complete_pulse", 64'(schedule_complete), 64'd1);
        chk("valid_after_last", 64'(w_valid), 64'd0);
        chk("busy_after_last", 64'(schedule_busy), 64'd0);
        step();
        @(negedge clock);
        chk("complete_one_cycle", 64'(schedule_complete), 64'd0);
        step();
        chk("beats_accepted", 64'(n_acc), 64'(ROUNDS));
        chk("index_order_errs", 64'(order_err), 64'd0);
        chk("stall_hold_errs", 64'(stall_err), 64'd0);
        chk("run_flag_errs", 64'(early_err), 64'd0);
    endtask

    task automatic chk_sched(input string name, input sch_t exp);
        for (int t = 0; t < 64; t++)
            chk($sformatf("%s_W%0d", name, t), 64'(got[t]), 64'(exp[t]));
    endtask

    initial begin
        vec_t abc_tab[6];
        int   n_acc, cycles, pulses, beats;

        blk_abc     = '0;
        blk_abc[0]  = 32'h61626380;
        blk_abc[15] = 32'h00000018;
        blk_ones    = '1;
        mdl_abc     = build_model(blk_abc);
        mdl_ones    = build_model(blk_ones);

        abc_tab[0] = '{"abc_W0",  0,  32'h61626380};
        abc_tab[1] = '{"abc_W1",  1,  32'h00000000};
        abc_tab[2] = '{"abc_W15", 15, 32'h00000018};
        abc_tab[3] = '{"abc_W16", 16, 32'h61626380};
        abc_tab[4] = '{"abc_W17", 17, 32'h000F0000};
        abc_tab[5] = '{"abc_W18", 18, 32'h7DA86405};

        reset = 1'b1; enable = 1'b1; message_vector_complete = 1'b0;
        message_vector = '0; w_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_valid", 64'(w_valid), 64'd0);
        chk("rst_busy", 64'(schedule_busy), 64'd0);
        chk("rst_complete", 64'(schedule_complete), 64'd0);
        chk("rst_index", 64'(w_index), 64'd0);
        chk("rst_word", 64'(w_word), 64'd0);
        step();

        // "abc" block, always ready: 64 back-to-back beats.
        start_block(blk_abc);
        collect(1'b0, -1, n_acc, cycles);
        chk("abc_cycles", 64'(cycles), 64'd64);
        foreach (abc_tab[i]) chk(abc_tab[i].name, 64'(got[abc_tab[i].idx]), 64'(abc_tab[i].exp));
        chk_sched("abc", mdl_abc);

        // Random backpressure gives the same sequence.
        start_block(blk_abc);
        collect(1'b1, -1, n_acc, cycles);
        chk_sched("bp", mdl_abc);

        // All-ones block exercises 32-bit wrap.
        start_block(blk_ones);
        collect(1'b0, -1, n_acc, cycles);
        chk("ones_W16", 64'(got[16]), 64'h203FFFFC);
        chk_sched("ones", mdl_ones);

        // Held level: exactly one schedule over 200 cycles.
        message_vector = to_vec(blk_abc);
        message_vector_complete = 1'b1;
        w_ready = 1'b1;
        pulses = 0; beats = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (schedule_complete) pulses++;
            if (w_valid && w_ready) beats++;
            step();
        end
        chk("held_pulses", 64'(pulses), 64'd1);
        chk("held_beats", 64'(beats), 64'd64);
        w_ready = 1'b0;
        message_vector_complete = 1'b0;
        step();
        start_block(blk_ones);
        collect(1'b0, -1, n_acc, cycles);
        chk_sched("rearm", mdl_ones);

        // Second rising edge at t=20 with a corrupted block is ignored.
        start_block(blk_abc);
        collect(1'b0, 20, n_acc, cycles);
        chk_sched("midstart", mdl_abc);

        // Reset at t=30 aborts, then a fresh block restarts cleanly.
        start_block(blk_abc);
        w_ready = 1'b1;
        repeat (30) step();
        @(negedge clock);
        chk("rst30_index", 64'(w_index), 64'd30);
        chk("rst30_word", 64'(w_word), 64'(mdl_abc[30]));
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("rst30_valid", 64'(w_valid), 64'd0);
        chk("rst30_busy", 64'(schedule_busy), 64'd0);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (schedule_complete) pulses++;
            step();
        end
        chk("rst30_no_pulse", 64'(pulses), 64'd0);
        w_ready = 1'b0;
        start_block(blk_ones);
        @(negedge clock);
        chk("rst30_new_W0", 64'(w_word), 64'(mdl_ones[0]));
        step();
        collect(1'b0, -1, n_acc, cycles);
        chk_sched("after_rst", mdl_ones);

        // enable=0 at t=30 behaves like reset.
        start_block(blk_ones);
        w_ready = 1'b1;
        repeat (30) step();
        @(negedge clock);
        chk("en30_index", 64'(w_index), 64'd30);
        enable = 1'b0;
        step();
        enable = 1'b1;
        @(negedge clock);
        chk("en30_valid", 64'(w_valid), 64'd0);
        chk("en30_busy", 64'(schedule_busy), 64'd0);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (schedule_complete) pulses++;
            step();
        end
        chk("en30_no_pulse", 64'(pulses), 64'd0);
        w_ready = 1'b0;
        start_block(blk_abc);
        @(negedge clock);
        chk("en30_new_W0", 64'(w_word), 64'(mdl_abc[0]));
        step();
        collect(1'b0, -1, n_acc, cycles);
        chk_sched("after_en", mdl_abc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/msg_schedule.md
Name: msg_schedule

Overview:
Downstream neighbour of the 512-bit padded-block former. Captures the block when `message_vector_complete` rises, then streams the 64 SHA-256 message-schedule words W0..W63, one per accepted beat, to the compression stage. Uses a 16-word sliding window, so no 64-entry storage is needed. Drives a ready/valid handshake toward the compression rounds.

Parameters:
- ROUNDS, 64, number of schedule words emitted per block. Legal range 17..64; SHA-256 requires 64.
- IDX_W, $clog2(ROUNDS), width of `w_index`. Derived; do not override.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  stage enable; low forces idle and clears outputs, same rule as the block former
- message_vector_complete  in  1  level from the block former; its rising edge is the start
- message_vector  in  512  padded block; word0 = [511:480], word15 = [31:0]
- w_ready  in  1  compression stage accepts `w_word` this cycle
- w_valid  out  1  `w_word` / `w_index` hold a valid schedule word
- w_index  out  IDX_W  round number t of `w_word`
- w_word  out  32  W_t
- schedule_busy  out  1  high from capture until the final word is accepted
- schedule_complete  out  1  one-cycle pulse after W_(ROUNDS-1) is accepted

Behaviour:
- One clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values, also applied whenever `enable`=0 at a clock edge:
  - state IDLE
  - `w_valid`, `schedule_busy`, `schedule_complete` = 0
  - `w_index` = 0, `w_word` = 0, window cleared
  - `mvc_q` (registered `message_vector_complete`) = 0
- Start detection: start = `message_vector_complete` & ~`mvc_q`. `mvc_q` updates every edge while enabled.
- States:
  - IDLE -> RUN on a start edge. At that edge win[i] <= message_vector[511-32i -: 32] for i = 0..15, `w_index` <= 0, `w_valid` <= 1, `schedule_busy` <= 1.
  - Latency: W0 is visible in the cycle after the start edge is sampled.
  - RUN: `w_word` = win[0] (combinational from the window, no extra register).
  - RUN, on `w_valid` & `w_ready`:
    - win[i] <= win[i+1] for i = 0..14
    - win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0], modulo 2^32
    - `w_index` <= `w_index` + 1
  - RUN, accept with `w_index` = ROUNDS-1 -> IDLE: `w_valid` <= 0, `schedule_busy` <= 0, `schedule_complete` <= 1 for exactly one cycle.
  - `w_ready` low: window, `w_index` and `w_word` hold unchanged. There is no timeout.
- Functions:
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3
  - s1(x) = ROTR17 ^ ROTR19 ^ SHR10
  - All adds are 32-bit wrapping; carries are discarded.
- W0..W15 are the block words verbatim. Expansion outputs start at t = 16.
- A start edge while in RUN is ignored; the edge is consumed by `mvc_q`. The upstream block must be re-presented after `schedule_complete`.
- A start edge in the same cycle as the final accept is ignored; the next start needs a fresh rising edge.
- `message_vector` is sampled only at the start edge. Later changes have no effect on the running schedule.
- Reset or `enable`=0 mid-RUN: the schedule aborts and no `schedule_complete` pulse is generated.
- `w_valid` never drops in RUN until the final beat is accepted.

Decomposition:
- Shared package `sha256_pkg`:
  - constants WORD_W = 32, BLOCK_W = 512, NUM_ROUNDS = 64
  - functions `sha_sigma0`, `sha_sigma1`; reused later by the compression round's Sigma0/Sigma1/Ch/Maj
- One natural sub-module: `msg_sched_expand`. Purely combinational; takes win[0], win[1], win[9], win[14] and returns the next window word.
- The FSM and window live in `msg_schedule`.

Test Plan:
- "abc" block (0x61626380, 13 zero words, 0x00000000, 0x00000018), `w_ready`=1 constant:
  - W0 = 0x61626380, W15 = 0x00000018, W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405
  - 64 consecutive valid beats, `w_index` 0..63
  - `schedule_complete` pulses once, on the cycle after index 63
  - all words match the golden model
- Backpressure: `w_ready` toggled with a random 50% pattern -> identical 64-word sequence to the unstalled run; `w_word`/`w_index` stable while `w_ready`=0.
- Held level: `message_vector_complete` held high for 200 cycles -> exactly one schedule. Drop it, raise it again -> a second schedule starts.
- Start during RUN: a second rising edge at t = 20 -> ignored; the schedule completes unaffected.
- Reset at t = 30 (and separately `enable`=0 at t = 30):
  - next cycle `w_valid` = 0, `schedule_busy` = 0, no complete pulse
  - a new start then produces W0 from the new block
- All-ones block (0xFFFFFFFF x16) -> W16 = 0xFFFFFFFF + 0xFFFFFFFF + s0(0xFFFFFFFF) + s1(0xFFFFFFFF), which exercises wrap; compare to the model.
